// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch: fetch FSM feeding a DEPTH-entry instruction FIFO.
// Define PREFETCH_BYPASS_EN to forward responses to decode when empty.
module instr_prefetch_queue #(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req_valid,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_req_ready,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            discard_q, discard_d;

   logic [XLEN-1:0] data_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]   count_q, count_n;

   logic rsp_keep, bypass, push, pop, room;

   // A response is kept only if it answers the current fetch stream.
   assign rsp_keep = (state_q == WAIT) && mem_rsp_valid
                     && !discard_q && !redirect_valid;

`ifdef PREFETCH_BYPASS_EN
   assign bypass = rsp_keep && (count_q == '0);
`else
   assign bypass = 1'b0;
`endif

   assign instr_valid = (count_q != '0) || bypass;
   assign instr       = bypass ? mem_rsp_data : data_mem[rd_ptr_q];
   assign instr_pc    = bypass ? req_pc_q : pc_mem[rd_ptr_q];

   assign push = rsp_keep && !(bypass && instr_ready);
   assign pop  = (count_q != '0) && instr_ready && !redirect_valid;

   assign count_n = redirect_valid ? '0
                  : count_q + CW'(push) - CW'(pop);
   assign room    = count_n < CW'(DEPTH);

   assign mem_req_valid = (state_q == REQ);
   assign mem_req_addr  = fetch_pc_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      discard_d  = discard_q;
      unique case (state_q)
         IDLE: begin
            if (room) state_d = REQ;
         end
         REQ: begin
            if (mem_req_ready) begin
               state_d    = WAIT;
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               discard_d = 1'b0;
               state_d   = room ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // An accepted-but-unanswered request must drain before refetching.
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         if (state_d == WAIT) begin
            discard_d = 1'b1;
         end else begin
            discard_d = 1'b0;
            state_d   = REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         discard_q  <= discard_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else if (redirect_valid) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            data_mem[wr_ptr_q] <= mem_rsp_data;
            pc_mem[wr_ptr_q]   <= req_pc_q;
            wr_ptr_q           <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_n;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: transaction-level queue model
// compared every cycle, plus directed scenarios with literal checks.
module tb_instr_prefetch_queue;

   localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   instr_prefetch_queue #(
      .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h100)
   ) dut (
      .clk(clk), .reset(reset),
      .mem_req_valid(mem_req_valid),
      .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .instr_valid(instr_valid),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory: answers one cycle after each accepted request when enabled.
   bit mem_auto = 1'b1;
   always begin
      logic        acc;
      logic [31:0] a;
      @(negedge clk);
      acc = mem_req_valid && mem_req_ready;
      a   = mem_req_addr;
      @(posedge clk);
      #1;
      if (mem_auto) begin
         mem_rsp_valid = acc;
         mem_rsp_data  = a ^ 32'h1300_0013;
      end
   end

   // Model: queue of {pc,data}, one outstanding slot, discard flag.
   logic [31:0] q_pc[$];
   logic [31:0] q_dat[$];
   logic [31:0] acc_log[$];
   logic [31:0] con_log[$];
   bit          out_v = 1'b0;
   bit          disc  = 1'b0;
   logic [31:0] out_pc = '0;
   logic [31:0] m_pc = 32'h100;
   int          n_push = 0;

   always @(negedge clk) begin
      bit          byp, ev, acc, rsp;
      logic [31:0] epc, edat;
      if (reset) begin
         q_pc.delete();
         q_dat.delete();
         out_v = 1'b0;
         disc  = 1'b0;
         m_pc  = 32'h100;
      end else begin
         byp = BYP && out_v && !disc && q_pc.size() == 0
               && mem_rsp_valid && !redirect_valid;
         ev  = q_pc.size() > 0 || byp;
         epc  = byp ? out_pc : (q_pc.size() > 0 ? q_pc[0] : '0);
         edat = byp ? mem_rsp_data
                    : (q_dat.size() > 0 ? q_dat[0] : '0);
         chk("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
         if (ev) begin
            chk("instr_pc", instr_pc, epc);
            chk("instr", instr, edat);
         end
         if (mem_req_valid) begin
            chk("req_addr", mem_req_addr, m_pc);
            chk("req_room", {31'b0, out_v || q_pc.size() >= DEPTH},
                32'd0);
         end
         acc = mem_req_valid && mem_req_ready;
         rsp = out_v && mem_rsp_valid;
         if (acc) acc_log.push_back(m_pc);
         if (redirect_valid) begin
            q_pc.delete();
            q_dat.delete();
            disc  = acc || (out_v && !rsp);
            out_v = disc;
            m_pc  = redirect_pc;
         end else begin
            if (q_pc.size() > 0 && instr_ready) begin
               con_log.push_back(q_pc[0]);
               void'(q_pc.pop_front());
               void'(q_dat.pop_front());
            end
            if (rsp) begin
               if (!disc) begin
                  if (byp && instr_ready) begin
                     con_log.push_back(out_pc);
                  end else begin
                     q_pc.push_back(out_pc);
                     q_dat.push_back(mem_rsp_data);
                     n_push++;
                  end
               end
               out_v = 1'b0;
               disc  = 1'b0;
            end
            if (acc) begin
               out_v  = 1'b1;
               out_pc = m_pc;
               m_pc   = m_pc + 32'd4;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_accept();
      bit found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req_valid && mem_req_ready) begin
            found = 1'b1;
            break;
         end
      end
      chk("accept_timeout", {31'b0, found}, 32'd1);
      cyc(1);
   endtask

   initial begin
      int n0;
      bit found;
      reset = 1'b1;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      cyc(1);
      @(negedge clk);
      chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'h100);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      cyc(1);
      reset = 1'b0;

      // Fill to DEPTH and stall.
      cyc(20);
      @(negedge clk);
      chk("stall_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("stall_n_req", acc_log.size(), 32'd4);
      for (int i = 0; i < 4; i++)
         chk("stall_req_seq", acc_log[i], 32'h100 + 32'(4 * i));
      chk("stall_head_pc", instr_pc, 32'h100);

      // Drain.
      cyc(1);
      instr_ready = 1'b1;
      cyc(30);
      chk("drain_count", {31'b0, con_log.size() >= 8}, 32'd1);
      for (int i = 0; i < 8; i++)
         chk("drain_seq", con_log[i], 32'h100 + 32'(4 * i));

      // Redirect while a request is in flight.
      instr_ready = 1'b0;
      cyc(20);
      mem_auto = 1'b0;
      mem_rsp_valid = 1'b0;
      instr_ready = 1'b1;
      cyc(1);
      instr_ready = 1'b0;
      wait_accept();
      @(negedge clk);
      chk("pre_redir_valid", {31'b0, instr_valid}, 32'd1);
      cyc(1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h2000;
      cyc(1);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir_flush", {31'b0, instr_valid}, 32'd0);
      chk("redir_hold_req", {31'b0, mem_req_valid}, 32'd0);
      cyc(1);
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hDEAD_BEEF;
      cyc(1);
      mem_rsp_valid = 1'b0;
      mem_auto = 1'b1;
      @(negedge clk);
      chk("drop_valid", {31'b0, instr_valid}, 32'd0);
      chk("redir_req_addr", mem_req_addr, 32'h2000);
      n0 = con_log.size();
      cyc(1);
      instr_ready = 1'b1;
      cyc(10);
      chk("redir_first_pc", con_log[n0], 32'h2000);

      // Address wrap.
      n0 = acc_log.size();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      cyc(1);
      redirect_valid = 1'b0;
      cyc(12);
      found = 1'b0;
      for (int i = n0; i < acc_log.size() - 1; i++) begin
         if (!found && acc_log[i] == 32'hFFFF_FFFC) begin
            found = 1'b1;
            chk("wrap_next", acc_log[i+1], 32'h0);
         end
      end
      chk("wrap_seen", {31'b0, found}, 32'd1);

      // Request held while memory not ready.
      mem_req_ready = 1'b0;
      cyc(6);
      instr_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h3000;
      cyc(1);
      redirect_valid = 1'b0;
      n0 = n_push;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'b0, mem_req_valid}, 32'd1);
         chk("hold_addr", mem_req_addr, 32'h3000);
         cyc(1);
      end
      mem_req_ready = 1'b1;
      cyc(1);
      mem_req_ready = 1'b0;
      cyc(5);
      chk("hold_one_push", n_push - n0, 32'd1);
      @(negedge clk);
      chk("hold_head_pc", instr_pc, 32'h3000);
      chk("hold_next_addr", mem_req_addr, 32'h3004);

      // Bypass / no-bypass latency on an empty queue.
      cyc(1);
      instr_ready = 1'b1;
      cyc(1);
      instr_ready = 1'b0;
      mem_auto = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      wait_accept();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'h0050_0093;
      instr_ready = 1'b1;
      @(negedge clk);
      if (BYP) begin
         chk("byp_valid", {31'b0, instr_valid}, 32'd1);
         chk("byp_instr", instr, 32'h0050_0093);
         chk("byp_pc", instr_pc, 32'h3004);
      end else begin
         chk("nobyp_valid0", {31'b0, instr_valid}, 32'd0);
      end
      cyc(1);
      mem_rsp_valid = 1'b0;
      instr_ready = 1'b0;
      @(negedge clk);
      if (BYP) begin
         chk("byp_occ0", {31'b0, instr_valid}, 32'd0);
      end else begin
         chk("nobyp_valid1", {31'b0, instr_valid}, 32'd1);
         chk("nobyp_instr", instr, 32'h0050_0093);
         chk("nobyp_pc", instr_pc, 32'h3004);
      end

      // Reset with a request outstanding; late response ignored.
      cyc(1);
      instr_ready = 1'b1;
      mem_req_ready = 1'b1;
      wait_accept();
      instr_ready = 1'b0;
      mem_req_ready = 1'b0;
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'h0000_0BAD;
      cyc(1);
      mem_rsp_valid = 1'b0;
      cyc(3);
      @(negedge clk);
      chk("rst_mid_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_mid_req", {31'b0, mem_req_valid}, 32'd1);
      chk("rst_mid_addr", mem_req_addr, 32'h100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected done");
      $fatal(1);
   end

endmodule
